// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter: a data port (one beat) and a 2*DW fetch port (two beats).
// Define ARB_RR_EN to alternate contested grants; otherwise the data port always wins.
module mem_port_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [2*DW-1:0] if_inst,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StDAcc,
    StDRsp,
    StFLo,
    StFHi,
    StFRsp
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] inst_hi_q, inst_lo_q;
  logic [DW-1:0] rdata_q;
  logic          d_wr_q;
  logic          grant_d, grant_f;

`ifdef ARB_RR_EN
  // 0: data wins the next contested grant, 1: fetch wins it
  logic prio_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (state_q == StIdle && d_req && if_req) begin
      prio_q <= ~prio_q;
    end
  end

  always_comb begin
    grant_d = d_req & (~if_req | ~prio_q);
    grant_f = if_req & ~grant_d;
  end
`else
  always_comb begin
    grant_d = d_req;
    grant_f = if_req & ~d_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StDAcc;
        end else if (grant_f) begin
          state_d = StFLo;
        end
      end
      StDAcc: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        state_d   = StDRsp;
      end
      StDRsp: begin
        d_ack   = 1'b1;
        state_d = StIdle;
      end
      StFLo: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        state_d  = StFHi;
      end
      StFHi: begin
        mem_en   = 1'b1;
        mem_addr = if_addr + AW'(1);
        state_d  = StFRsp;
      end
      StFRsp: begin
        if_ack  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The response beat arrives in the ack cycle itself, so it is bypassed onto the outputs
  always_comb begin
    if_inst = {inst_hi_q, inst_lo_q};
    d_rdata = rdata_q;
    if (state_q == StFRsp) begin
      if_inst = {inst_hi_q, mem_rdata};
    end
    if (state_q == StDRsp && !d_wr_q) begin
      d_rdata = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      inst_hi_q <= '0;
      inst_lo_q <= '0;
      rdata_q   <= '0;
      d_wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDAcc) begin
        d_wr_q <= d_we;
      end
      if (state_q == StDRsp && !d_wr_q) begin
        rdata_q <= mem_rdata;
      end
      if (state_q == StFHi) begin
        inst_hi_q <= mem_rdata;
      end
      if (state_q == StFRsp) begin
        inst_lo_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requesters and a memory, checked against a
// transaction-level model with its own copy of the memory contents.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we;
  logic [AW-1:0]   if_addr, d_addr, mem_addr;
  logic [DW-1:0]   d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [2*DW-1:0] if_inst;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_inst   (if_inst),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory the DUT really talks to, and the model's expectation of its contents
  logic [DW-1:0] sim_mem [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sim_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= sim_mem[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: kind 0 = idle, 1 = data, 2 = fetch; start = the IDLE cycle that granted it
  int              kind, start, ph;
  logic            m_we, prio, post_rst, rst_done, e_en, e_we, e_dack, e_iack;
  logic            d_busy, f_busy, d_done, f_done, data_wins;
  logic [AW-1:0]   m_addr, m_addr1;
  logic [DW-1:0]   m_wdata, m_dval, exp_rdata;
  logic [2*DW-1:0] m_ival, exp_inst;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = DW'($urandom);
      ref_mem[i] = sim_mem[i];
    end
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    kind = 0; start = 0; prio = 1'b0; exp_rdata = '0; exp_inst = '0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_dval = '0; m_ival = '0;
    d_busy = 1'b0; f_busy = 1'b0; rst_done = 1'b0; post_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      ph = cyc - start;
      m_addr1 = m_addr + AW'(1);
      e_en = 1'b0; e_we = 1'b0; e_dack = 1'b0; e_iack = 1'b0;
      if (kind == 1 && ph == 1) begin e_en = 1'b1; e_we = m_we; end
      if (kind == 1 && ph == 2) begin
        e_dack = 1'b1;
        if (!m_we) exp_rdata = m_dval;
      end
      if (kind == 2 && (ph == 1 || ph == 2)) e_en = 1'b1;
      if (kind == 2 && ph == 3) begin e_iack = 1'b1; exp_inst = m_ival; end

      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_we);
      check("d_ack", d_ack, e_dack);
      check("if_ack", if_ack, e_iack);
      check("d_rdata", d_rdata, exp_rdata);
      check("if_inst", if_inst, exp_inst);
      if (e_en) begin
        if (kind == 2 && ph == 2) check("mem_addr_hi", mem_addr, m_addr1);
        else                      check("mem_addr", mem_addr, m_addr);
        if (e_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (post_rst) begin
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        post_rst = 1'b0;
      end
      d_done = e_dack;
      f_done = e_iack;

      if (rst) begin
        kind = 0; prio = 1'b0; exp_rdata = '0; exp_inst = '0;
        d_busy = d_req; f_busy = if_req;
      end else if ((kind == 1 && ph == 2) || (kind == 2 && ph == 3)) begin
        kind = 0;
      end else if (kind == 0 && (d_req || if_req)) begin
`ifdef ARB_RR_EN
        data_wins = d_req && (!if_req || !prio);
        if (d_req && if_req) prio = ~prio;
`else
        data_wins = d_req;
`endif
        start = cyc;
        if (data_wins) begin
          kind = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          if (d_we) ref_mem[d_addr] = d_wdata;
          else      m_dval = ref_mem[d_addr];
        end else begin
          kind = 2; m_addr = if_addr; m_addr1 = if_addr + AW'(1);
          m_ival = {ref_mem[if_addr], ref_mem[m_addr1]};
        end
      end

      @(posedge clk);
      #1;
      if (rst) begin
        rst = 1'b0;
        post_rst = 1'b1;
      end else if (!rst_done && cyc > 400 && kind == 2 && cyc == start + 1) begin
        // Now in the second fetch beat: abort it
        rst = 1'b1;
        rst_done = 1'b1;
      end
      if (d_done) begin d_busy = 1'b0; d_req = 1'b0; end
      if (f_done) begin f_busy = 1'b0; if_req = 1'b0; end
      // Accepted transactions must finish even if the requester lets go
      if (kind == 1 && d_req && !d_done && $urandom_range(0, 3) == 0) d_req = 1'b0;
      if (!d_busy && $urandom_range(0, 2) == 0) begin
        d_busy = 1'b1; d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 15));
        d_wdata = DW'($urandom);
      end
      if (!f_busy && $urandom_range(0, 2) == 0) begin
        f_busy = 1'b1; if_req = 1'b1;
        if ($urandom_range(0, 3) == 0) if_addr = '1;
        else                           if_addr = AW'($urandom_range(0, 15));
      end
    end
    check("abort_reset_seen", rst_done, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
